// File: rtl/pipeline_if.sv
// Instruction-fetch stage: owns the PC, issues in-order imem requests, and queues returned words for decode.
// Define IF_PERF_CNT_EN to add the perf_fetched / perf_dropped event counters.
module pipeline_if #(
    parameter int unsigned     XLEN       = 32,
    parameter logic [XLEN-1:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned     FIFO_DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_resp_valid,
    input  logic [XLEN-1:0] imem_resp_data,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    input  logic            id_ready,
    output logic            inst_valid,
    output logic [XLEN-1:0] inst,
    output logic [XLEN-1:0] inst_pc
`ifdef IF_PERF_CNT_EN
    ,
    output logic [31:0]     perf_fetched,
    output logic [31:0]     perf_dropped
`endif
);

    localparam int unsigned AW      = $clog2(FIFO_DEPTH);
    localparam int unsigned CW      = AW + 1;
    localparam logic [CW:0] DEPTH_W = (CW + 1)'(FIFO_DEPTH);

    logic [XLEN-1:0]       pc_q, pc_d;
    logic [AW-1:0]         head_q, head_d;
    logic [AW-1:0]         tail_q, tail_d;
    logic [AW-1:0]         fill_q, fill_d;
    logic [CW-1:0]         count_q, count_d;
    logic [CW-1:0]         unfilled_q, unfilled_d;
    logic [CW-1:0]         drop_q, drop_d;
    logic [FIFO_DEPTH-1:0] filled_q, filled_d;
    logic [XLEN-1:0]       hold_inst_q, hold_pc_q;
    logic [XLEN-1:0]       ent_pc_q   [FIFO_DEPTH];
    logic [XLEN-1:0]       ent_data_q [FIFO_DEPTH];

    logic          head_filled;
    logic          push;
    logic          pop;
    logic          resp_fill;
    logic          resp_discard;
    logic [CW:0]   in_use;
    logic [CW-1:0] pending;

    // Credit covers both live queue entries and stale responses still owed by memory.
    assign in_use  = {1'b0, count_q} + {1'b0, drop_q};
    assign pending = drop_q + unfilled_q;

    assign head_filled    = filled_q[head_q];
    assign imem_req_valid = !rst && !redirect_valid && (in_use < DEPTH_W);
    assign imem_req_addr  = pc_q;
    assign push           = imem_req_valid && imem_req_ready;

    assign inst_valid = head_filled && !redirect_valid;
    assign pop        = inst_valid && id_ready;
    assign inst       = head_filled ? ent_data_q[head_q] : hold_inst_q;
    assign inst_pc    = head_filled ? ent_pc_q[head_q]   : hold_pc_q;

    assign resp_fill    = imem_resp_valid && !redirect_valid && (drop_q == '0) && (unfilled_q != '0);
    assign resp_discard = imem_resp_valid && (redirect_valid ? (pending != '0) : (drop_q != '0));

    always_comb begin
        pc_d       = pc_q;
        head_d     = head_q;
        tail_d     = tail_q;
        fill_d     = fill_q;
        count_d    = count_q;
        unfilled_d = unfilled_q;
        drop_d     = drop_q;
        if (redirect_valid) begin
            pc_d       = redirect_pc;
            head_d     = '0;
            tail_d     = '0;
            fill_d     = '0;
            count_d    = '0;
            unfilled_d = '0;
            // Every unfilled entry turns into a response that must be thrown away.
            drop_d     = pending - CW'(resp_discard);
        end else begin
            if (push) begin
                pc_d   = pc_q + XLEN'(4);
                tail_d = tail_q + 1'b1;
            end
            if (pop) begin
                head_d = head_q + 1'b1;
            end
            if (resp_fill) begin
                fill_d = fill_q + 1'b1;
            end
            count_d    = count_q + CW'(push) - CW'(pop);
            unfilled_d = unfilled_q + CW'(push) - CW'(resp_fill);
            drop_d     = drop_q - CW'(resp_discard);
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < FIFO_DEPTH; gi = gi + 1) begin : g_flag
            assign filled_d[gi] = !redirect_valid &&
                ((resp_fill && (fill_q == AW'(gi))) ||
                 (filled_q[gi] && !(pop && (head_q == AW'(gi)))));
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q        <= RESET_PC;
            head_q      <= '0;
            tail_q      <= '0;
            fill_q      <= '0;
            count_q     <= '0;
            unfilled_q  <= '0;
            drop_q      <= '0;
            filled_q    <= '0;
            hold_inst_q <= '0;
            hold_pc_q   <= '0;
        end else begin
            pc_q        <= pc_d;
            head_q      <= head_d;
            tail_q      <= tail_d;
            fill_q      <= fill_d;
            count_q     <= count_d;
            unfilled_q  <= unfilled_d;
            drop_q      <= drop_d;
            filled_q    <= filled_d;
            hold_inst_q <= inst;
            hold_pc_q   <= inst_pc;
        end
    end

    // Payload storage needs no reset; the filled flags decide what is meaningful.
    always_ff @(posedge clk) begin
        if (push) begin
            ent_pc_q[tail_q] <= pc_q;
        end
        if (resp_fill) begin
            ent_data_q[fill_q] <= imem_resp_data;
        end
    end

`ifdef IF_PERF_CNT_EN
    logic [31:0] perf_fetched_q, perf_dropped_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_fetched_q <= '0;
            perf_dropped_q <= '0;
        end else begin
            perf_fetched_q <= perf_fetched_q + 32'(pop);
            perf_dropped_q <= perf_dropped_q + 32'(resp_discard);
        end
    end

    assign perf_fetched = perf_fetched_q;
    assign perf_dropped = perf_dropped_q;
`endif

endmodule

// File: tb/tb_pipeline_if.sv
// Randomized bench for pipeline_if: an epoch-tagged request model plus an in-order memory model predict every cycle.
`timescale 1ns/1ps
module tb_pipeline_if;
    localparam int          DEPTH = 2;
    localparam logic [31:0] RPC   = 32'h0000_0100;

    logic        clk = 1'b0;
    logic        rst, imem_req_valid, imem_req_ready, imem_resp_valid;
    logic        redirect_valid, id_ready, inst_valid;
    logic [31:0] imem_req_addr, imem_resp_data, redirect_pc, inst, inst_pc;
    logic        w_req_valid, w_inst_valid;
    logic [31:0] w_req_addr, w_inst, w_inst_pc;
`ifdef IF_PERF_CNT_EN
    logic [31:0] perf_fetched, perf_dropped, w_pf, w_pd;
`endif

    always #5 clk = ~clk;

    pipeline_if #(.XLEN(32), .RESET_PC(RPC), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
        .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .id_ready(id_ready), .inst_valid(inst_valid), .inst(inst), .inst_pc(inst_pc)
`ifdef IF_PERF_CNT_EN
        , .perf_fetched(perf_fetched), .perf_dropped(perf_dropped)
`endif
    );

    // Second instance only to observe PC wrap from the top of the address space.
    pipeline_if #(.XLEN(32), .RESET_PC(32'hFFFF_FFFC), .FIFO_DEPTH(DEPTH)) u_wrap (
        .clk(clk), .rst(rst),
        .imem_req_valid(w_req_valid), .imem_req_ready(1'b1), .imem_req_addr(w_req_addr),
        .imem_resp_valid(1'b0), .imem_resp_data(32'h0),
        .redirect_valid(1'b0), .redirect_pc(32'h0),
        .id_ready(1'b1), .inst_valid(w_inst_valid), .inst(w_inst), .inst_pc(w_inst_pc)
`ifdef IF_PERF_CNT_EN
        , .perf_fetched(w_pf), .perf_dropped(w_pd)
`endif
    );

    typedef struct { logic [31:0] addr; int epoch; int due; } mreq_t;
    typedef struct { logic [31:0] pc; bit arrived; } ent_t;

    mreq_t       memq[$];
    ent_t        rbuf[$];
    logic [31:0] obs_deliv[$];
    int          epoch, cyc, last_due, mem_lat;
    bit          mem_jit, m_push, m_pop, resp_now;
    logic [31:0] mpc, last_pc, last_inst;
    int          total, bad;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'hDEAD_BEEF;
    endfunction

    function automatic int stale_cnt();
        int n = 0;
        foreach (memq[i]) if (memq[i].epoch != epoch) n++;
        return n;
    endfunction

    // Drive memory, let outputs settle, compare against the model, and decide this cycle's handshakes.
    task automatic settle();
        bit          exp_rv, exp_iv, head_ok;
        logic [31:0] exp_pc, exp_inst;
        resp_now        = (memq.size() > 0) && (memq[0].due <= cyc);
        imem_resp_valid = resp_now;
        imem_resp_data  = resp_now ? mem_word(memq[0].addr) : $urandom();
        #1;
        m_push = 1'b0;
        m_pop  = 1'b0;
        if (rst) begin
            total++;
            if (imem_req_valid !== 1'b0) begin
                bad++; $display("FAIL req_valid_in_reset got=%0b want=0", imem_req_valid);
            end
        end else begin
            head_ok  = (rbuf.size() > 0) && rbuf[0].arrived;
            exp_rv   = !redirect_valid && (rbuf.size() + stale_cnt() < DEPTH);
            exp_iv   = head_ok && !redirect_valid;
            exp_pc   = head_ok ? rbuf[0].pc : last_pc;
            exp_inst = head_ok ? mem_word(rbuf[0].pc) : last_inst;
            total++;
            if (imem_req_valid !== exp_rv) begin
                bad++; $display("FAIL req_valid cyc=%0d got=%0b want=%0b", cyc, imem_req_valid, exp_rv);
            end
            if (exp_rv) begin
                total++;
                if (imem_req_addr !== mpc) begin
                    bad++; $display("FAIL req_addr cyc=%0d got=%08h want=%08h", cyc, imem_req_addr, mpc);
                end
            end
            total++;
            if (inst_valid !== exp_iv) begin
                bad++; $display("FAIL inst_valid cyc=%0d got=%0b want=%0b", cyc, inst_valid, exp_iv);
            end
            total++;
            if (inst_pc !== exp_pc) begin
                bad++; $display("FAIL inst_pc cyc=%0d got=%08h want=%08h", cyc, inst_pc, exp_pc);
            end
            total++;
            if (inst !== exp_inst) begin
                bad++; $display("FAIL inst cyc=%0d got=%08h want=%08h", cyc, inst, exp_inst);
            end
            last_pc   = exp_pc;
            last_inst = exp_inst;
            m_push    = exp_rv && imem_req_ready;
            m_pop     = exp_iv && id_ready;
            if (inst_valid && id_ready) begin
                obs_deliv.push_back(inst_pc);
                $display("xfer cyc=%0d pc=%08h inst=%08h", cyc, inst_pc, inst);
            end
        end
    endtask

    // Advance one clock and apply the cycle's events to the model.
    task automatic tick();
        mreq_t r;
        int    d;
        @(posedge clk);
        cyc++;
        if (rst) begin
            memq.delete(); rbuf.delete();
            epoch++; mpc = RPC; last_pc = '0; last_inst = '0; last_due = 0;
        end else begin
            if (resp_now) begin
                r = memq.pop_front();
                if (!redirect_valid && r.epoch == epoch) begin
                    for (int i = 0; i < rbuf.size(); i++) begin
                        if (!rbuf[i].arrived) begin rbuf[i].arrived = 1'b1; break; end
                    end
                end
            end
            if (redirect_valid) begin
                epoch++; rbuf.delete(); mpc = redirect_pc;
            end else begin
                if (m_pop) void'(rbuf.pop_front());
                if (m_push) begin
                    d = cyc - 1 + (mem_jit ? 1 + int'($urandom_range(0, 2)) : mem_lat);
                    if (d <= last_due) d = last_due + 1;
                    last_due = d;
                    memq.push_back('{mpc, epoch, d});
                    rbuf.push_back('{mpc, 1'b0});
                    mpc = mpc + 32'd4;
                end
            end
        end
        @(negedge clk);
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin settle(); tick(); end
    endtask

    task automatic do_reset();
        rst = 1'b1; redirect_valid = 1'b0; redirect_pc = '0; id_ready = 1'b1; imem_req_ready = 1'b1;
        step(2);
        rst = 1'b0;
        obs_deliv.delete();
    endtask

    task automatic test_reset();
        mem_lat = 1; mem_jit = 0;
        do_reset();
        settle();
        total++;
        if (imem_req_valid !== 1'b1 || imem_req_addr !== RPC) begin
            bad++; $display("FAIL reset_first_req got=%0b/%08h want=1/%08h", imem_req_valid, imem_req_addr, RPC);
        end
        total++;
        if (inst_valid !== 1'b0 || inst !== 32'h0 || inst_pc !== 32'h0) begin
            bad++; $display("FAIL reset_outputs got=%0b/%08h/%08h want=0/0/0", inst_valid, inst, inst_pc);
        end
        tick();
    endtask

    task automatic test_stream();
        mem_lat = 1; mem_jit = 0;
        do_reset();
        step(30);
        total++;
        if (obs_deliv.size() < 15) begin
            bad++; $display("FAIL stream_count got=%0d want>=15", obs_deliv.size());
        end
        foreach (obs_deliv[i]) begin
            total++;
            if (obs_deliv[i] !== RPC + 32'(4 * i)) begin
                bad++; $display("FAIL stream_seq idx=%0d got=%08h want=%08h", i, obs_deliv[i], RPC + 32'(4 * i));
            end
        end
    endtask

    task automatic test_stall();
        int reqs = 0;
        mem_lat = 1; mem_jit = 0;
        do_reset();
        id_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            settle();
            if (imem_req_valid && imem_req_ready) reqs++;
            tick();
        end
        total++;
        if (reqs != 2) begin bad++; $display("FAIL stall_reqs got=%0d want=2", reqs); end
        settle();
        total++;
        if (inst_valid !== 1'b1 || inst_pc !== RPC || inst !== mem_word(RPC) || imem_req_valid !== 1'b0) begin
            bad++; $display("FAIL stall_hold got=%0b/%08h/%08h rv=%0b want=1/%08h/%08h rv=0",
                            inst_valid, inst_pc, inst, imem_req_valid, RPC, mem_word(RPC));
        end
        tick();
        id_ready = 1'b1;
        step(6);
        total++;
        if (obs_deliv.size() < 2 || obs_deliv[0] !== RPC || obs_deliv[1] !== RPC + 32'd4) begin
            bad++; $display("FAIL stall_resume got_n=%0d want first=%08h,%08h", obs_deliv.size(), RPC, RPC + 32'd4);
        end
    endtask

    task automatic test_redirect();
        mem_lat = 3; mem_jit = 0;
        do_reset();
        step(2);
        redirect_valid = 1'b1; redirect_pc = 32'h0000_0200;
        step(1);
        redirect_valid = 1'b0;
        settle();
        total++;
        if (imem_req_valid !== 1'b0) begin bad++; $display("FAIL redir_credit got=%0b want=0", imem_req_valid); end
        tick();
        step(20);
        total++;
        if (obs_deliv.size() < 1 || obs_deliv[0] !== 32'h200) begin
            bad++; $display("FAIL redir_first got_n=%0d want first=00000200", obs_deliv.size());
        end
        foreach (obs_deliv[i]) begin
            total++;
            if (obs_deliv[i] < 32'h200) begin bad++; $display("FAIL redir_stale got=%08h want>=00000200", obs_deliv[i]); end
        end
    endtask

    task automatic test_redirect_collide();
        mem_lat = 1; mem_jit = 0;
        do_reset();
        id_ready = 1'b0;
        step(2);
        id_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h0000_0300;
        settle();
        total++;
        if (inst_valid !== 1'b0 || imem_req_valid !== 1'b0 || imem_resp_valid !== 1'b1) begin
            bad++; $display("FAIL collide_cycle got iv=%0b rv=%0b want iv=0 rv=0", inst_valid, imem_req_valid);
        end
        tick();
        redirect_valid = 1'b0;
        settle();
        total++;
        if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h300) begin
            bad++; $display("FAIL collide_restart got=%0b/%08h want=1/00000300", imem_req_valid, imem_req_addr);
        end
        tick();
        step(8);
        total++;
        if (obs_deliv.size() < 1 || obs_deliv[0] !== 32'h300) begin
            bad++; $display("FAIL collide_first got_n=%0d want first=00000300", obs_deliv.size());
        end
    endtask

    task automatic test_wrap();
        mem_lat = 1; mem_jit = 0;
        do_reset();
        redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFF8;
        settle();
        total++;
        if (w_req_valid !== 1'b1 || w_req_addr !== 32'hFFFF_FFFC) begin
            bad++; $display("FAIL wrap_first got=%0b/%08h want=1/fffffffc", w_req_valid, w_req_addr);
        end
        tick();
        redirect_valid = 1'b0;
        settle();
        total++;
        if (w_req_valid !== 1'b1 || w_req_addr !== 32'h0) begin
            bad++; $display("FAIL wrap_second got=%0b/%08h want=1/00000000", w_req_valid, w_req_addr);
        end
        total++;
        if (w_inst_valid !== 1'b0 || w_inst_pc !== 32'h0) begin
            bad++; $display("FAIL wrap_idle got=%0b/%08h want=0/00000000", w_inst_valid, w_inst_pc);
        end
        tick();
        step(14);
        total++;
        if (obs_deliv.size() < 3 || obs_deliv[0] !== 32'hFFFF_FFF8 || obs_deliv[1] !== 32'hFFFF_FFFC || obs_deliv[2] !== 32'h0) begin
            bad++; $display("FAIL wrap_seq got_n=%0d want fffffff8,fffffffc,00000000", obs_deliv.size());
        end
    endtask

    task automatic test_reset_mid();
        mem_lat = 1; mem_jit = 0;
        do_reset();
        id_ready = 1'b0;
        step(3);
        rst = 1'b1;
        step(1);
        rst = 1'b0; id_ready = 1'b1;
        obs_deliv.delete();
        settle();
        total++;
        if (inst_valid !== 1'b0 || inst !== 32'h0 || inst_pc !== 32'h0) begin
            bad++; $display("FAIL rstmid_outputs got=%0b/%08h/%08h want=0/0/0", inst_valid, inst, inst_pc);
        end
        total++;
        if (imem_req_valid !== 1'b1 || imem_req_addr !== RPC) begin
            bad++; $display("FAIL rstmid_req got=%0b/%08h want=1/%08h", imem_req_valid, imem_req_addr, RPC);
        end
        tick();
        settle();
        total++;
        if (inst_valid !== 1'b0) begin bad++; $display("FAIL rstmid_stale got=%0b want=0", inst_valid); end
        tick();
        step(6);
    endtask

    task automatic test_random();
        mem_jit = 1;
        do_reset();
        for (int i = 0; i < 800; i++) begin
            imem_req_ready = ($urandom_range(0, 3) != 0);
            id_ready       = ($urandom_range(0, 2) != 0);
            redirect_valid = ($urandom_range(0, 15) == 0);
            case ($urandom_range(0, 3))
                0:       redirect_pc = 32'hFFFF_FFF8;
                1:       redirect_pc = $urandom();
                default: redirect_pc = $urandom() & 32'h0000_FFFC;
            endcase
            rst = ($urandom_range(0, 199) == 0);
            settle();
            tick();
        end
        rst = 1'b0; redirect_valid = 1'b0;
    endtask

    initial begin
        total = 0; bad = 0; cyc = 0; epoch = 0; last_due = 0;
        mpc = RPC; last_pc = '0; last_inst = '0; mem_lat = 1; mem_jit = 0;
        rst = 1'b1; redirect_valid = 1'b0; redirect_pc = '0; id_ready = 1'b1; imem_req_ready = 1'b1;
        imem_resp_valid = 1'b0; imem_resp_data = '0;
        @(negedge clk);
        test_reset();
        test_stream();
        test_stall();
        test_redirect();
        test_redirect_collide();
        test_wrap();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
